// File: rtl/ec1_datapath.sv
// ec1_datapath -- datapath of the EC-1 accumulator machine.
//
// Holds the program counter, instruction register, A accumulator, program
// memory and a registered output port. The control unit drives the load /
// mux strobes; the datapath hands back the decoded opcode and the A-not-zero
// flag, both taken from registers, so they are stable one cycle before the
// control unit makes its next state decision.
//
// Optional feature: define EC1_INSTR_COUNT_EN to add a 16-bit saturating
// count of instruction fetches (edges with IRload=1) on port instr_count.
//
// Ports:
//   clk         system clock, rising edge
//   Reset       asynchronous active-high reset (PC, IR, A, Output, strobe)
//   IRload      IR <= mem[PC]
//   PCload      update PC
//   JNZmux      PC source: 0 = PC+1, 1 = IR jump field
//   INmux       A source:  0 = A-1,  1 = Input
//   Aload       load A
//   OutE        capture A into Output
//   Input       external data for IN
//   prog_we     program memory write enable (honoured even during Reset)
//   prog_addr   program write address
//   prog_data   program write data
//   opcode      IR[DATA_W-1:DATA_W-3]
//   AnotZero    |A
//   Output      registered output value
//   out_strobe  one-cycle pulse after each Output capture
//   instr_count fetch counter (only with EC1_INSTR_COUNT_EN)
//   pc          current PC

module ec1_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              IRload,
  input  logic              PCload,
  input  logic              JNZmux,
  input  logic              INmux,
  input  logic              Aload,
  input  logic              OutE,
  input  logic [DATA_W-1:0] Input,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [2:0]        opcode,
  output logic              AnotZero,
  output logic [DATA_W-1:0] Output,
  output logic              out_strobe,
`ifdef EC1_INSTR_COUNT_EN
  output logic [15:0]       instr_count,
`endif
  output logic [ADDR_W-1:0] pc
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] mem_rd;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] a_next;

  // Asynchronous read at PC; a same-edge write therefore lands after IR has
  // already sampled the old word (read-before-write).
  assign mem_rd = mem[pc];

  // NOTE: memories get no reset branch -- contents must survive Reset, and a
  // reset loop over the array would stop it mapping onto RAM. Keeping the
  // write out of the reset process also lets prog_we work during Reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_next = pc;
    a_next  = a;
    if (PCload) begin
      pc_next = JNZmux ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
    end
    if (Aload) begin
      a_next = INmux ? Input : a - DATA_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes IR take mem[old PC] while PC
  // advances, and Output take the old A while A updates, on the same edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc         <= '0;
      ir         <= '0;
      a          <= '0;
      Output     <= '0;
      out_strobe <= 1'b0;
    end else begin
      pc         <= pc_next;
      a          <= a_next;
      out_strobe <= OutE;
      if (IRload) begin
        ir <= mem_rd;
      end
      if (OutE) begin
        Output <= a;
      end
    end
  end

`ifdef EC1_INSTR_COUNT_EN
  // Saturating fetch counter; cleared only by Reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      instr_count <= '0;
    end else if (IRload && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

  assign opcode   = ir[DATA_W-1 -: 3];
  assign AnotZero = |a;

endmodule

// File: tb/tb_ec1_datapath.sv
module tb_ec1_datapath;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic              IRload = 1'b0;
  logic              PCload = 1'b0;
  logic              JNZmux = 1'b0;
  logic              INmux = 1'b0;
  logic              Aload = 1'b0;
  logic              OutE = 1'b0;
  logic [DATA_W-1:0] Input = '0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic [2:0]        opcode;
  logic              AnotZero;
  logic [DATA_W-1:0] Output;
  logic              out_strobe;
  logic [ADDR_W-1:0] pc;
`ifdef EC1_INSTR_COUNT_EN
  logic [15:0]       instr_count;
`endif

  ec1_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .IRload     (IRload),
    .PCload     (PCload),
    .JNZmux     (JNZmux),
    .INmux      (INmux),
    .Aload      (Aload),
    .OutE       (OutE),
    .Input      (Input),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .opcode     (opcode),
    .AnotZero   (AnotZero),
    .Output     (Output),
    .out_strobe (out_strobe),
`ifdef EC1_INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .pc         (pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard of Output values expected on each out_strobe pulse.
  logic [DATA_W-1:0] out_q[$];
  logic [DATA_W-1:0] mon_exp;

  always @(negedge clk) begin
    if (!Reset && out_strobe) begin
      vectors++;
      if (out_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: Output=%h with nothing expected", Output);
      end else begin
        mon_exp = out_q.pop_front();
        if (Output !== mon_exp) begin
          miscompares++;
          $display("FAIL out_scoreboard: got %h want %h", Output, mon_exp);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic step(input logic ir, input logic pcl, input logic jnz,
                      input logic inm, input logic al, input logic oe);
    IRload = ir; PCload = pcl; JNZmux = jnz; INmux = inm; Aload = al; OutE = oe;
    @(posedge clk); #1;
    IRload = 0; PCload = 0; JNZmux = 0; INmux = 0; Aload = 0; OutE = 0;
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic test_reset;
    #1 Reset = 1'b1;
    #2;
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", pc); end
    vectors++; if (opcode !== 3'd0) begin miscompares++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
    vectors++; if (AnotZero !== 1'b0) begin miscompares++; $display("FAIL reset_anz: got %b want 0", AnotZero); end
    vectors++; if (Output !== 8'h00) begin miscompares++; $display("FAIL reset_output: got %h want 00", Output); end
    vectors++; if (out_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b want 0", out_strobe); end
    write_mem(5'd0, 8'h60);
    write_mem(5'd1, 8'h80);
    Reset = 1'b0;
  endtask

  task automatic test_fetch;
    step(1, 1, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b011) begin miscompares++; $display("FAIL fetch1_opcode: got %b want 011", opcode); end
    vectors++; if (pc !== 5'd1) begin miscompares++; $display("FAIL fetch1_pc: got %0d want 1", pc); end
    step(1, 1, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b100) begin miscompares++; $display("FAIL fetch2_opcode: got %b want 100", opcode); end
    vectors++; if (pc !== 5'd2) begin miscompares++; $display("FAIL fetch2_pc: got %0d want 2", pc); end
    for (int i = 0; i < 29; i++) step(0, 1, 0, 0, 0, 0);
    vectors++; if (pc !== 5'd31) begin miscompares++; $display("FAIL pc_top: got %0d want 31", pc); end
    step(0, 1, 0, 0, 0, 0);
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL pc_wrap: got %0d want 0", pc); end
  endtask

  task automatic test_in_dec;
    Input = 8'h02;
    step(0, 0, 0, 1, 1, 0);
    vectors++; if (AnotZero !== 1'b1) begin miscompares++; $display("FAIL in_anz: got %b want 1", AnotZero); end
    step(0, 0, 0, 0, 1, 0);
    vectors++; if (AnotZero !== 1'b1) begin miscompares++; $display("FAIL dec1_anz: got %b want 1", AnotZero); end
    step(0, 0, 0, 0, 1, 0);
    vectors++; if (AnotZero !== 1'b0) begin miscompares++; $display("FAIL dec2_anz: got %b want 0", AnotZero); end
    step(0, 0, 0, 0, 1, 0);
    vectors++; if (AnotZero !== 1'b1) begin miscompares++; $display("FAIL dec_wrap_anz: got %b want 1", AnotZero); end
    out_q.push_back(8'hFF);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jnz;
    write_mem(5'd3, 8'hC1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b110) begin miscompares++; $display("FAIL jnz_opcode: got %b want 110", opcode); end
    vectors++; if (pc !== 5'd4) begin miscompares++; $display("FAIL jnz_pre_pc: got %0d want 4", pc); end
    step(0, 0, 1, 0, 0, 0);
    vectors++; if (pc !== 5'd4) begin miscompares++; $display("FAIL jnz_hold_pc: got %0d want 4", pc); end
    step(0, 1, 1, 0, 0, 0);
    vectors++; if (pc !== 5'd1) begin miscompares++; $display("FAIL jnz_jump_pc: got %0d want 1", pc); end
  endtask

  task automatic test_output;
    Input = 8'h2A;
    step(0, 0, 0, 1, 1, 0);
    out_q.push_back(8'h2A);
    step(0, 0, 0, 0, 0, 1);
    vectors++; if (out_strobe !== 1'b1) begin miscompares++; $display("FAIL out_strobe_hi: got %b want 1", out_strobe); end
    vectors++; if (Output !== 8'h2A) begin miscompares++; $display("FAIL out_value: got %h want 2a", Output); end
    step(0, 0, 0, 0, 0, 0);
    vectors++; if (out_strobe !== 1'b0) begin miscompares++; $display("FAIL out_strobe_lo: got %b want 0", out_strobe); end
    vectors++; if (Output !== 8'h2A) begin miscompares++; $display("FAIL out_hold: got %h want 2a", Output); end
    // OutE with Aload: Output takes pre-edge A, A still decrements.
    out_q.push_back(8'h2A);
    step(0, 0, 0, 0, 1, 1);
    out_q.push_back(8'h29);
    step(0, 0, 0, 0, 0, 1);
    // INmux without Aload must leave A alone.
    Input = 8'h00;
    step(0, 0, 0, 1, 0, 0);
    out_q.push_back(8'h29);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_read_before_write;
    // pc is 1 and mem[1] holds 8'h80.
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 8'hE5; IRload = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0; IRload = 1'b0;
    vectors++; if (opcode !== 3'b100) begin miscompares++; $display("FAIL rbw_old: got %b want 100", opcode); end
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b111) begin miscompares++; $display("FAIL rbw_new: got %b want 111", opcode); end
    step(0, 1, 1, 0, 0, 0);
    vectors++; if (pc !== 5'd5) begin miscompares++; $display("FAIL rbw_low_bits: got %0d want 5", pc); end
  endtask

  task automatic test_reset_mid;
    write_mem(5'd5, 8'h43);
    Input = 8'h05;
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    vectors++; if (pc !== 5'd3 || Output !== 8'h05 || opcode !== 3'b010 || AnotZero !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: pc=%0d Output=%h opcode=%b anz=%b want 3 05 010 1", pc, Output, opcode, AnotZero);
    end
    #2 Reset = 1'b1;
    #1;
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL mid_pc: got %0d want 0", pc); end
    vectors++; if (AnotZero !== 1'b0) begin miscompares++; $display("FAIL mid_a: got %b want 0", AnotZero); end
    vectors++; if (opcode !== 3'd0) begin miscompares++; $display("FAIL mid_ir: got %b want 000", opcode); end
    vectors++; if (Output !== 8'h00) begin miscompares++; $display("FAIL mid_output: got %h want 00", Output); end
    vectors++; if (out_strobe !== 1'b0) begin miscompares++; $display("FAIL mid_strobe: got %b want 0", out_strobe); end
    @(posedge clk); #1;
    write_mem(5'd1, 8'h49);
    Reset = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b011) begin miscompares++; $display("FAIL mem_keep0: got %b want 011", opcode); end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b110) begin miscompares++; $display("FAIL mem_keep3: got %b want 110", opcode); end
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    vectors++; if (opcode !== 3'b010) begin miscompares++; $display("FAIL we_in_reset_op: got %b want 010", opcode); end
    step(0, 1, 1, 0, 0, 0);
    vectors++; if (pc !== 5'd9) begin miscompares++; $display("FAIL we_in_reset_pc: got %0d want 9", pc); end
  endtask

  typedef enum logic [1:0] {C_FETCH, C_DECODE, C_EXEC, C_HALT} cu_t;

  task automatic test_program;
    cu_t st;
    logic [2:0] op;
    Reset = 1'b1;
    @(posedge clk); #1;
    write_mem(5'd0, 8'h60);
    write_mem(5'd1, 8'h80);
    write_mem(5'd2, 8'hA0);
    write_mem(5'd3, 8'hC1);
    write_mem(5'd4, 8'hE0);
    Input = 8'h03;
    Reset = 1'b0;
`ifdef EC1_INSTR_COUNT_EN
    vectors++; if (instr_count !== 16'd0) begin miscompares++; $display("FAIL count_reset: got %0d want 0", instr_count); end
`endif
    out_q.push_back(8'h03);
    out_q.push_back(8'h02);
    out_q.push_back(8'h01);
    st = C_FETCH;
    op = 3'b000;
    for (int cyc = 0; cyc < 300 && st != C_HALT; cyc++) begin
      case (st)
        C_FETCH: begin
          step(1, 1, 0, 0, 0, 0);
          st = C_DECODE;
        end
        C_DECODE: begin
          op = opcode;
          step(0, 0, 0, 0, 0, 0);
          st = (op == 3'b111) ? C_HALT : C_EXEC;
        end
        default: begin
          case (op)
            3'b011:  step(0, 0, 0, 1, 1, 0);
            3'b100:  step(0, 0, 0, 0, 0, 1);
            3'b101:  step(0, 0, 0, 0, 1, 0);
            3'b110:  step(0, AnotZero, 1, 0, 0, 0);
            default: step(0, 0, 0, 0, 0, 0);
          endcase
          st = C_FETCH;
        end
      endcase
    end
    vectors++; if (st != C_HALT) begin miscompares++; $display("FAIL prog_timeout: state %0d want HALT", st); end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    vectors++; if (pc !== 5'd5) begin miscompares++; $display("FAIL halt_pc: got %0d want 5", pc); end
    vectors++; if (out_q.size() != 0) begin miscompares++; $display("FAIL prog_outputs: %0d outputs missing want 0", out_q.size()); end
    vectors++; if (Output !== 8'h01) begin miscompares++; $display("FAIL halt_output: got %h want 01", Output); end
`ifdef EC1_INSTR_COUNT_EN
    vectors++; if (instr_count !== 16'd11) begin miscompares++; $display("FAIL halt_count: got %0d want 11", instr_count); end
    step(0, 0, 0, 0, 0, 0);
    vectors++; if (instr_count !== 16'd11) begin miscompares++; $display("FAIL halt_count_hold: got %0d want 11", instr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_in_dec();
    test_jnz();
    test_output();
    test_read_before_write();
    test_reset_mid();
    test_program();
    vectors++;
    if (out_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", out_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
